// File: rtl/sync_dr_tx_pkg.sv
// Shared definitions for the dual-rail synchronous-to-asynchronous transmitter.
package sync_dr_tx_pkg;

  localparam logic [15:0] ENC_TP = "TP";
  localparam logic [15:0] ENC_FP = "FP";

  localparam int unsigned RAIL0 = 0;
  localparam int unsigned RAIL1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_dr_tx_ack_sync.sv
// Two-flop synchronizer bringing the asynchronous downstream acknowledge into clk.
module ack_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ack,
  output logic o_ack_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_ack;
      r_sync <= r_meta;
    end
  end

  assign o_ack_s = r_sync;

endmodule

// File: rtl/sync_dr_tx.sv
// Dual-rail token transmitter: encodes a word as a two-phase or four-phase
// dual-rail codeword and handshakes it against a synchronized acknowledge.
module sync_dr_tx
  import sync_dr_tx_pkg::*;
#(
  parameter logic [15:0] ENC      = ENC_TP,
  parameter int unsigned WIDTH    = 4,
  localparam int unsigned RAIL_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]   out,
  input  logic                             ack_i,
  output logic                             proto_err
);

  localparam bit IS_FP = (ENC == ENC_FP);

  state_t r_state;
  state_t w_next;

  logic                           w_ack_s;
  logic                           w_accept;
  logic                           w_ack_expected;
  logic                           w_spacer;
  logic                           r_phase;
  logic                           r_err;
  logic [WIDTH-1:0][RAIL_NUM-1:0] r_out;
  logic [WIDTH-1:0][RAIL_NUM-1:0] w_code;

  ack_sync u_ack_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ack   (ack_i),
    .o_ack_s (w_ack_s)
  );

  assign w_accept       = in_valid && in_ready;
  assign w_spacer       = (r_out == '0);
  assign w_ack_expected = IS_FP ? 1'b0 : r_phase;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = SEND;
      SEND: begin
        if (IS_FP) begin
          if (w_ack_s) w_next = RTZ;
        end else if (w_ack_s == r_phase) begin
          w_next = IDLE;
        end
      end
      RTZ:     if (!w_ack_s && w_spacer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE) && !rst;
  end

  // TP flips the rail selected by each data bit; FP drives a fresh one-hot pair.
  always_comb begin
    w_code = r_out;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (IS_FP) begin
        w_code[i][RAIL1] = in_data[i];
        w_code[i][RAIL0] = ~in_data[i];
      end else if (in_data[i]) begin
        w_code[i][RAIL1] = ~r_out[i][RAIL1];
      end else begin
        w_code[i][RAIL0] = ~r_out[i][RAIL0];
      end
    end
  end

  // FP spacer is launched on the first RTZ cycle, one cycle after the ack is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_phase <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out   <= w_code;
        r_phase <= ~r_phase;
      end else if (IS_FP && (r_state == RTZ)) begin
        r_out <= '0;
      end
      if ((r_state == IDLE) && (w_ack_s != w_ack_expected)) r_err <= 1'b1;
    end
  end

  assign out       = r_out;
  assign proto_err = r_err;

endmodule

// File: tb/tb_sync_dr_tx.sv
// Directed bench for sync_dr_tx: one FP and one TP instance, each driving a
// behavioural downstream mem_reg that acknowledges after 0-5 time units.
module tb_sync_dr_tx;

  logic clk;
  logic rst_fp, rst_tp;
  logic [3:0] fp_data, tp_data;
  logic fp_valid, tp_valid;
  logic fp_ready, tp_ready;
  logic [3:0][1:0] fp_out, tp_out;
  logic fp_ack, tp_ack;
  logic fp_err, tp_err;
  logic fp_ack_m, tp_ack_m, fp_spur;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_dr_tx #(.ENC("FP"), .WIDTH(4)) dut_fp (
    .clk(clk), .rst(rst_fp), .in_data(fp_data), .in_valid(fp_valid),
    .in_ready(fp_ready), .out(fp_out), .ack_i(fp_ack), .proto_err(fp_err)
  );

  sync_dr_tx #(.ENC("TP"), .WIDTH(4)) dut_tp (
    .clk(clk), .rst(rst_tp), .in_data(tp_data), .in_valid(tp_valid),
    .in_ready(tp_ready), .out(tp_out), .ack_i(tp_ack), .proto_err(tp_err)
  );

  // Four-phase downstream: ack a complete codeword, release on spacer.
  logic [3:0] fp_dec;
  bit fp_comp, fp_sp;
  int unsigned fp_dly;
  logic [3:0] fp_q[$];
  always @(fp_out or rst_fp) begin
    fp_comp = 1'b1;
    fp_sp   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fp_comp &= (fp_out[i][1] ^ fp_out[i][0]);
      fp_sp   &= (fp_out[i] == 2'b00);
      fp_dec[i] = fp_out[i][1];
    end
    fp_dly = $urandom_range(0, 5);
    if (rst_fp) fp_ack_m = 1'b0;
    else if (fp_comp) begin
      fp_q.push_back(fp_dec);
      #(fp_dly);
      fp_ack_m = 1'b1;
    end else if (fp_sp) begin
      #(fp_dly);
      fp_ack_m = 1'b0;
    end
  end
  assign fp_ack = fp_ack_m | fp_spur;

  // Two-phase downstream: a bit is 1 when its rail1 toggled; ack toggles per token.
  logic [3:0][1:0] tp_prev;
  logic [3:0] tp_dec;
  int unsigned tp_dly;
  logic [3:0] tp_q[$];
  always @(tp_out or rst_tp) begin
    tp_dly = $urandom_range(0, 5);
    if (rst_tp) begin
      tp_ack_m = 1'b0;
      tp_prev  = '0;
    end else if (tp_out != tp_prev) begin
      for (int i = 0; i < 4; i++) tp_dec[i] = tp_out[i][1] ^ tp_prev[i][1];
      tp_q.push_back(tp_dec);
      tp_prev = tp_out;
      #(tp_dly);
      tp_ack_m = ~tp_ack_m;
    end
  end
  assign tp_ack = tp_ack_m;

  task automatic test_reset();
    rst_fp = 1'b1; rst_tp = 1'b1;
    fp_valid = 1'b0; tp_valid = 1'b0; fp_data = '0; tp_data = '0; fp_spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (fp_ready !== 1'b0) $display("FAIL rst_fp_ready: got %b want 0", fp_ready);
    else n_cmp = n_cmp; if (fp_ready !== 1'b0) n_bad++;
    n_cmp++; if (fp_out !== 8'h00 || fp_err !== 1'b0) begin
      $display("FAIL rst_fp_out: got out=%h err=%b want 00/0", fp_out, fp_err); n_bad++; end
    n_cmp++; if (tp_ready !== 1'b0 || tp_out !== 8'h00 || tp_err !== 1'b0) begin
      $display("FAIL rst_tp: got rdy=%b out=%h err=%b want 0/00/0", tp_ready, tp_out, tp_err); n_bad++; end
    rst_fp = 1'b0; rst_tp = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (fp_ready !== 1'b1 || tp_ready !== 1'b1) begin
      $display("FAIL post_rst_ready: got fp=%b tp=%b want 1/1", fp_ready, tp_ready); n_bad++; end
  endtask

  task automatic test_fp_token();
    logic [7:0] exp_out;
    logic exp_rdy;
    fp_q.delete();
    @(negedge clk);
    fp_data = 4'b1010; fp_valid = 1'b1;
    n_cmp++; if (fp_ready !== 1'b1) begin $display("FAIL fp_tok_ready0: got %b want 1", fp_ready); n_bad++; end
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      fp_valid = 1'b0; fp_data = 4'b0101;
      exp_out = (k < 4) ? 8'h99 : 8'h00;
      exp_rdy = (k == 7);
      n_cmp++; if (fp_out !== exp_out) begin
        $display("FAIL fp_tok_out[%0d]: got %h want %h", k, fp_out, exp_out); n_bad++; end
      n_cmp++; if (fp_ready !== exp_rdy) begin
        $display("FAIL fp_tok_ready[%0d]: got %b want %b", k, fp_ready, exp_rdy); n_bad++; end
    end
    n_cmp++; if (fp_q.size() != 1 || fp_q[0] !== 4'b1010 || fp_err !== 1'b0) begin
      $display("FAIL fp_tok_deliver: got n=%0d err=%b want 1 word 1010 err 0", fp_q.size(), fp_err); n_bad++; end
  endtask

  task automatic test_tp_tokens();
    logic [7:0] exp_out;
    logic exp_rdy;
    tp_q.delete();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      tp_data = 4'b0001; tp_valid = 1'b1;
      n_cmp++; if (tp_ready !== 1'b1) begin $display("FAIL tp_ready0[%0d]: got %b want 1", t, tp_ready); n_bad++; end
      @(posedge clk);
      exp_out = (t == 0) ? 8'h56 : 8'h00;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        tp_valid = 1'b0; tp_data = 4'b1110;
        exp_rdy = (k == 3);
        n_cmp++; if (tp_out !== exp_out) begin
          $display("FAIL tp_out[%0d][%0d]: got %h want %h", t, k, tp_out, exp_out); n_bad++; end
        n_cmp++; if (tp_ready !== exp_rdy) begin
          $display("FAIL tp_ready[%0d][%0d]: got %b want %b", t, k, tp_ready, exp_rdy); n_bad++; end
      end
      repeat (2) @(negedge clk);
      n_cmp++; if (tp_err !== 1'b0 || tp_out !== exp_out) begin
        $display("FAIL tp_idle_hold[%0d]: got out=%h err=%b want %h/0", t, tp_out, tp_err, exp_out); n_bad++; end
    end
    n_cmp++; if (tp_q.size() != 2 || tp_q[0] !== 4'b0001 || tp_q[1] !== 4'b0001) begin
      $display("FAIL tp_deliver: got n=%0d want 2 words of 0001", tp_q.size()); n_bad++; end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [8] = '{4'h3, 4'hC, 4'h0, 4'hF, 4'h5, 4'hA, 4'h9, 4'h6};
    int gap;
    fp_q.delete();
    @(negedge clk);
    fp_valid = 1'b1;
    for (int w = 0; w < 8; w++) begin
      n_cmp++; if (fp_ready !== 1'b1) begin $display("FAIL b2b_ready[%0d]: got %b want 1", w, fp_ready); n_bad++; end
      fp_data = words[w];
      @(posedge clk);
      gap = 0;
      do begin
        @(negedge clk);
        fp_data = ~words[w];
        if (!fp_ready) gap++;
      end while (!fp_ready && gap < 20);
      n_cmp++; if (gap != 7) begin $display("FAIL b2b_busy[%0d]: got %0d cycles want 7", w, gap); n_bad++; end
    end
    fp_valid = 1'b0;
    n_cmp++; if (fp_q.size() != 8) begin $display("FAIL b2b_count: got %0d want 8", fp_q.size()); n_bad++; end
    for (int w = 0; w < 8; w++) begin
      if (w < fp_q.size()) begin
        n_cmp++; if (fp_q[w] !== words[w]) begin
          $display("FAIL b2b_word[%0d]: got %h want %h", w, fp_q[w], words[w]); n_bad++; end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_rdy;
    fp_q.delete();
    @(negedge clk);
    fp_data = 4'b1111; fp_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    fp_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_fp = 1'b1;
    n_cmp++; if (fp_ready !== 1'b0) begin $display("FAIL mid_rst_ready: got %b want 0", fp_ready); n_bad++; end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (fp_out !== 8'h00 || fp_ready !== 1'b0 || fp_err !== 1'b0) begin
      $display("FAIL mid_rst_state: got out=%h rdy=%b err=%b want 00/0/0", fp_out, fp_ready, fp_err); n_bad++; end
    @(posedge clk); @(negedge clk);
    rst_fp = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (fp_ready !== 1'b1 || fp_out !== 8'h00) begin
      $display("FAIL mid_rst_after: got rdy=%b out=%h want 1/00", fp_ready, fp_out); n_bad++; end
    fp_data = 4'b0110; fp_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      fp_valid = 1'b0;
      exp_rdy = (k == 7);
      if (k == 0) begin
        n_cmp++; if (fp_out !== 8'h69) begin $display("FAIL mid_rst_code: got %h want 69", fp_out); n_bad++; end
      end
      n_cmp++; if (fp_ready !== exp_rdy) begin
        $display("FAIL mid_rst_ready[%0d]: got %b want %b", k, fp_ready, exp_rdy); n_bad++; end
    end
    n_cmp++; if (fp_q.size() != 2 || fp_q[fp_q.size()-1] !== 4'b0110 || fp_err !== 1'b0) begin
      $display("FAIL mid_rst_deliver: got n=%0d err=%b want 2 words ending 0110 err 0", fp_q.size(), fp_err); n_bad++; end
  endtask

  task automatic test_spurious_ack();
    int c;
    @(negedge clk);
    n_cmp++; if (fp_err !== 1'b0) begin $display("FAIL spur_pre: got %b want 0", fp_err); n_bad++; end
    fp_spur = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      fp_spur = 1'b0;
      c++;
    end while (!fp_err && c < 3);
    n_cmp++; if (fp_err !== 1'b1) begin $display("FAIL spur_detect: got %b after %0d cycles want 1", fp_err, c); n_bad++; end
    repeat (5) @(negedge clk);
    fp_data = 4'b0011; fp_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    fp_valid = 1'b0;
    n_cmp++; if (fp_out !== 8'h5A || fp_err !== 1'b1) begin
      $display("FAIL spur_operate: got out=%h err=%b want 5A/1", fp_out, fp_err); n_bad++; end
    repeat (7) @(negedge clk);
    n_cmp++; if (fp_ready !== 1'b1 || fp_err !== 1'b1) begin
      $display("FAIL spur_sticky: got rdy=%b err=%b want 1/1", fp_ready, fp_err); n_bad++; end
    rst_fp = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_fp = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (fp_err !== 1'b0) begin $display("FAIL spur_clear: got %b want 0", fp_err); n_bad++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fp_token();
    test_tp_tokens();
    test_back_to_back();
    test_reset_mid();
    test_spurious_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_dr_tx.md
SYNC_DR_TX -- requirements
Module: sync_dr_tx

Interface
REQ-001 Parameter ENC, default "TP": link protocol; "TP" is two-phase transition signalling, "FP" is four-phase return-to-zero.
REQ-002 Parameter WIDTH, default 4: data bits per token.
REQ-003 Localparam RAIL_NUM = 2: rails per bit; rail[1] encodes logic 1, rail[0] encodes logic 0.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  WIDTH  word to transmit.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 out  output  [WIDTH-1:0][RAIL_NUM-1:0]  dual-rail token driven into the downstream mem_reg stage; driven from flops only.
REQ-010 ack_i  input  1  asynchronous acknowledge from the downstream stage (its ack_o).
REQ-011 proto_err  output  1  sticky flag for an acknowledge protocol violation.

Function
REQ-012 ack_i shall pass through a 2-flop synchronizer before any use; ack_s denotes the synchronized value.
REQ-013 FSM states: IDLE, SEND, RTZ. RTZ is used only when ENC="FP".
REQ-014 in_ready shall be 1 only in IDLE; a word is accepted on a cycle where in_valid and in_ready are both 1.
REQ-015 On acceptance at cycle N, the FSM enters SEND and out carries the codeword from cycle N+1.
REQ-016 FP codeword: for each bit i, rail[in_data[i]] = 1 and the other rail = 0. Spacer: all rails 0.
REQ-017 TP codeword: for each bit i, rail[in_data[i]] toggles and the other rail holds. A phase bit toggles with each token.
REQ-018 FP, SEND: hold the codeword until ack_s = 1. Then, on the next cycle, out = spacer and the FSM enters RTZ.
REQ-019 FP, RTZ: hold the spacer until ack_s = 0, then enter IDLE. out stays spacer in IDLE.
REQ-020 TP, SEND: hold out until ack_s equals the phase bit, then enter IDLE. out keeps its rail levels and is never cleared.
REQ-021 Data sampling: in_data is captured only at acceptance; changes to in_data or in_valid outside IDLE have no effect.
REQ-022 Earliest return to IDLE after acceptance at cycle N:
  - TP: N+4 (ack_i transitions at N+1, two synchronizer stages, one FSM cycle).
  - FP: N+8.
REQ-023 Protocol error:
  - Condition: in IDLE, ack_s differs from its expected value (FP: 0; TP: the phase bit).
  - Response: proto_err is set and held until reset.
  - The FSM still operates normally.
REQ-024 An acknowledge that arrives in the same cycle as the FSM transition is honoured; the FSM does not stall an extra cycle.

Reset
REQ-025 While rst = 1: FSM = IDLE, out = all zeros, phase = 0, synchronizer flops = 0, proto_err = 0, in_ready = 0.
REQ-026 From the first cycle after rst deasserts, in_ready = 1.
REQ-027 Reset during SEND or RTZ shall abort the token and discard it. The downstream stage must be reset in the same cycle; this is a system-level constraint.

Structure
REQ-028 A shared package holds:
  - the ENC encoding names ("TP", "FP");
  - the rail index constants (RAIL0 = 0, RAIL1 = 1);
  - the FSM state enum.
REQ-029 The 2-flop synchronizer is a separate sub-module named ack_sync. The encoder and FSM stay in sync_dr_tx.
REQ-030 Target size: 120-400 lines of RTL in total.

Verification
REQ-031 Run every scenario below against a behavioural mem_reg model with random ack delays of 0-5 ns.
REQ-032 FP, WIDTH=4:
  - Stimulus: in_data = 4'b1010 accepted at cycle 10.
  - Response: out = {10,01,10,01} from cycle 11 until ack_s rises, then all zeros; in_ready = 1 again from cycle 18 at the earliest.
REQ-033 TP, WIDTH=4, starting from reset:
  - Stimulus: send 4'b0001, then 4'b0001.
  - Response: out = {01,01,01,10} after the first token and {00,00,00,00}... — see REQ-034 for the exact rail values.
REQ-034 TP rail values for REQ-033:
  - After token 1, out = {01,01,01,10}, meaning bits 3..1 have rail0 = 1 and bit 0 has rail1 = 1.
  - After token 2, the same rails toggle back, so out = all zeros.
  - Phase returns to 0.
REQ-035 Back-pressure:
  - Stimulus: hold in_valid = 1 with 8 consecutive words.
  - Response: every word is delivered in order exactly once; in_ready = 0 throughout SEND and RTZ.
REQ-036 Reset mid-operation:
  - Stimulus: assert rst in SEND (FP).
  - Response: out = 0, in_ready = 0 during reset and 1 afterwards; a new word is accepted and delivered correctly.
REQ-037 Spurious acknowledge:
  - Stimulus: pulse ack_i high in IDLE (FP).
  - Response: proto_err = 1 within 3 cycles and stays 1 until rst.
